// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: zero-fills the register file after reset, then shares its single write port
// between pipeline writeback (priority) and a buffered load-return FIFO. Option: REGFILE_WR_CONFLICT_CNT_EN.
module regfile_wr_sched #(
    parameter int NUM_THREADS   = 4,
    parameter int DWIDTH        = 32,
    parameter int LD_FIFO_DEPTH = 2,
    localparam int TW           = $clog2(NUM_THREADS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wb_valid,
    input  logic [TW-1:0]     i_wb_thread,
    input  logic [4:0]        i_wb_addr,
    input  logic [DWIDTH-1:0] i_wb_data,
    input  logic              i_ld_valid,
    output logic              o_ld_ready,
    input  logic [TW-1:0]     i_ld_thread,
    input  logic [4:0]        i_ld_addr,
    input  logic [DWIDTH-1:0] i_ld_data,
    output logic              o_rf_wr_en,
    output logic [TW-1:0]     o_rf_thread,
    output logic [4:0]        o_rf_addr,
    output logic [DWIDTH-1:0] o_rf_data,
    output logic              o_init_done,
    output logic [15:0]       o_conflict_cnt
);
    localparam int RF_SIZE = 32 * NUM_THREADS;
    localparam int CW      = $clog2(RF_SIZE) + 1;
    localparam int PW      = $clog2(LD_FIFO_DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_init_cnt;
    logic [PW:0]       r_count;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [TW-1:0]     r_fifo_thread [LD_FIFO_DEPTH];
    logic [4:0]        r_fifo_addr   [LD_FIFO_DEPTH];
    logic [DWIDTH-1:0] r_fifo_data   [LD_FIFO_DEPTH];

    logic w_run, w_wb_wr, w_nonempty, w_pop, w_push;

    assign w_run      = r_state == S_RUN;
    assign w_wb_wr    = w_run && i_wb_valid && i_wb_addr != 5'd0;
    assign w_nonempty = r_count != '0;
    // Pop decision uses registered occupancy, so a load accepted this cycle cannot also drain this cycle.
    assign w_pop      = w_run && !w_wb_wr && w_nonempty;
    assign o_ld_ready = w_run && r_count != (PW+1)'(LD_FIFO_DEPTH);
    assign w_push     = i_ld_valid && o_ld_ready && i_ld_addr != 5'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_INIT;
            r_init_cnt  <= '0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            o_rf_wr_en  <= 1'b0;
            o_rf_thread <= '0;
            o_rf_addr   <= '0;
            o_rf_data   <= '0;
            o_init_done <= 1'b0;
        end else begin
            o_rf_wr_en <= 1'b0;
            if (r_state == S_INIT) begin
                if (r_init_cnt == CW'(RF_SIZE)) begin
                    o_init_done <= 1'b1;
                    r_state     <= S_RUN;
                end else begin
                    o_rf_wr_en               <= 1'b1;
                    {o_rf_thread, o_rf_addr} <= r_init_cnt[CW-2:0];
                    o_rf_data                <= '0;
                    r_init_cnt               <= r_init_cnt + CW'(1);
                end
            end else if (w_wb_wr) begin
                o_rf_wr_en  <= 1'b1;
                o_rf_thread <= i_wb_thread;
                o_rf_addr   <= i_wb_addr;
                o_rf_data   <= i_wb_data;
            end else if (w_pop) begin
                o_rf_wr_en  <= 1'b1;
                o_rf_thread <= r_fifo_thread[r_rd_ptr];
                o_rf_addr   <= r_fifo_addr[r_rd_ptr];
                o_rf_data   <= r_fifo_data[r_rd_ptr];
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_thread[r_wr_ptr] <= i_ld_thread;
            r_fifo_addr[r_wr_ptr]   <= i_ld_addr;
            r_fifo_data[r_wr_ptr]   <= i_ld_data;
        end
    end

`ifdef REGFILE_WR_CONFLICT_CNT_EN
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_conflict_cnt <= '0;
        else if (w_wb_wr && w_nonempty && r_conflict_cnt != 16'hFFFF) r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end

    assign o_conflict_cnt = r_conflict_cnt;
`else
    assign o_conflict_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb_regfile_wr_sched: directed plus randomized stimulus against a queue-based reference model.
module tb_regfile_wr_sched;
    localparam int NT = 4, DW = 32, DEPTH = 2, RF = 32 * NT, TW = $clog2(NT);

    logic clk = 1'b0, reset_n = 1'b0;
    logic i_wb_valid = 1'b0, i_ld_valid = 1'b0;
    logic [TW-1:0] i_wb_thread = '0, i_ld_thread = '0;
    logic [4:0] i_wb_addr = '0, i_ld_addr = '0;
    logic [DW-1:0] i_wb_data = '0, i_ld_data = '0;
    logic o_ld_ready, o_rf_wr_en, o_init_done;
    logic [TW-1:0] o_rf_thread;
    logic [4:0] o_rf_addr;
    logic [DW-1:0] o_rf_data;
    logic [15:0] o_conflict_cnt;

    always #5 clk = ~clk;

    regfile_wr_sched #(.NUM_THREADS(NT), .DWIDTH(DW), .LD_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_wb_valid(i_wb_valid), .i_wb_thread(i_wb_thread), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_thread(i_ld_thread), .i_ld_addr(i_ld_addr),
        .i_ld_data(i_ld_data), .o_rf_wr_en(o_rf_wr_en), .o_rf_thread(o_rf_thread), .o_rf_addr(o_rf_addr),
        .o_rf_data(o_rf_data), .o_init_done(o_init_done), .o_conflict_cnt(o_conflict_cnt)
    );

    typedef struct packed {logic [TW-1:0] t; logic [4:0] a; logic [DW-1:0] d;} wr_t;

    wr_t q[$];
    wr_t m_last;
    bit m_run, m_we, m_done, acc;
    int m_idx, m_conf, n_vec, n_err, nwr;
    logic [DW-1:0] got[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = '0;
        m_run = 0; m_we = 0; m_done = 0; m_idx = 0; m_conf = 0;
    endtask

    task automatic chk_reset();
        chk("rst_wr_en", o_rf_wr_en, 0);
        chk("rst_thread", o_rf_thread, 0);
        chk("rst_addr", o_rf_addr, 0);
        chk("rst_data", o_rf_data, 0);
        chk("rst_done", o_init_done, 0);
        chk("rst_ready", o_ld_ready, 0);
        chk("rst_conf", o_conflict_cnt, 0);
    endtask

    task automatic idle();
        i_wb_valid = 0; i_ld_valid = 0;
    endtask

    // One clock: predict the port winner from the model, advance the edge, compare everything.
    task automatic cycle();
        bit rdy;
        int exp_conf;
        rdy = m_run && q.size() < DEPTH;
        chk("ld_ready", o_ld_ready, rdy);
        acc = i_ld_valid && rdy;
        m_we = 0;
        if (!m_run) begin
            if (m_idx < RF) begin
                m_we = 1;
                m_last = '{t: TW'(m_idx / 32), a: 5'(m_idx % 32), d: DW'(0)};
                m_idx++;
            end else begin
                m_run = 1; m_done = 1;
            end
        end else if (i_wb_valid && i_wb_addr != 0) begin
            m_we = 1;
            m_last = '{t: i_wb_thread, a: i_wb_addr, d: i_wb_data};
            if (q.size() > 0 && m_conf < 65535) m_conf++;
        end else if (q.size() > 0) begin
            m_we = 1;
            m_last = q.pop_front();
        end
        if (acc && i_ld_addr != 0) q.push_back('{t: i_ld_thread, a: i_ld_addr, d: i_ld_data});
        @(posedge clk);
        #1;
`ifdef REGFILE_WR_CONFLICT_CNT_EN
        exp_conf = m_conf;
`else
        exp_conf = 0;
`endif
        chk("wr_en", o_rf_wr_en, m_we);
        chk("thread", o_rf_thread, m_last.t);
        chk("addr", o_rf_addr, m_last.a);
        chk("data", o_rf_data, m_last.d);
        chk("init_done", o_init_done, m_done);
        chk("conflict", o_conflict_cnt, exp_conf);
    endtask

    task automatic do_init();
        nwr = 0;
        for (int i = 0; i < RF + 1; i++) begin
            cycle();
            if (o_rf_wr_en) nwr++;
        end
        chk("init_writes", nwr, 128);
        chk("init_done_edge", o_init_done, 1);
        chk("init_end_wr_en", o_rf_wr_en, 0);
        chk("ready_with_done", o_ld_ready, 1);
    endtask

    task automatic set_ld(input logic [TW-1:0] t, input logic [4:0] a, input logic [DW-1:0] d);
        i_ld_valid = 1; i_ld_thread = t; i_ld_addr = a; i_ld_data = d;
    endtask

    task automatic set_wb(input logic [TW-1:0] t, input logic [4:0] a, input logic [DW-1:0] d);
        i_wb_valid = 1; i_wb_thread = t; i_wb_addr = a; i_wb_data = d;
    endtask

    initial begin
        model_reset();
        #2 chk_reset();
        @(negedge clk) reset_n = 1;
        do_init();

        set_wb(2, 5, 32'hDEADBEEF);
        cycle();
        chk("wb_data", o_rf_data, 32'hDEADBEEF);
        chk("wb_addr", o_rf_addr, 5);
        idle();
        cycle();
        chk("wb_then_idle", o_rf_wr_en, 0);

        set_wb(1, 0, 32'h1234);
        set_ld(3, 0, 32'h5678);
        cycle();
        chk("x0_no_write", o_rf_wr_en, 0);
        idle();
        cycle();
        chk("x0_ready", o_ld_ready, 1);

        set_wb(0, 1, 32'h100);
        set_ld(1, 7, 32'h11);
        cycle();
        i_ld_valid = 0;
        set_wb(0, 2, 32'h200);
        cycle();
        set_wb(0, 3, 32'h300);
        cycle();
        idle();
        cycle();
        chk("deferred_ld_data", o_rf_data, 32'h11);
        chk("deferred_ld_addr", o_rf_addr, 7);
`ifdef REGFILE_WR_CONFLICT_CNT_EN
        chk("deferred_conf", o_conflict_cnt, 2);
`else
        chk("deferred_conf", o_conflict_cnt, 0);
`endif

        set_wb(1, 9, 32'h900);
        set_ld(0, 3, 32'hA);
        cycle();
        set_ld(3, 9, 32'hB);
        cycle();
        set_ld(2, 4, 32'hC);
        for (int i = 0; i < 3; i++) cycle();
        chk("full_stall", o_ld_ready, 0);
        i_wb_valid = 0;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (acc) i_ld_valid = 0;
            if (o_rf_wr_en) got.push_back(o_rf_data);
        end
        chk("order_0", got[0], 32'hA);
        chk("order_1", got[1], 32'hB);
        chk("order_2", got[2], 32'hC);

        set_wb(2, 8, 32'h800);
        set_ld(1, 10, 32'hBAD1);
        cycle();
        set_ld(2, 11, 32'hBAD2);
        cycle();
        idle();
        chk("two_entries_full", o_ld_ready, 0);
        reset_n = 0;
        #1 chk_reset();
        model_reset();
        @(negedge clk) reset_n = 1;
        do_init();

        for (int i = 0; i < 800; i++) begin
            i_wb_valid = 1'($urandom_range(0, 1));
            i_wb_thread = TW'($urandom);
            i_wb_addr = 5'($urandom);
            i_wb_data = $urandom;
            if (!i_ld_valid && $urandom_range(0, 2) == 0)
                set_ld(TW'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
            cycle();
            if (acc) i_ld_valid = 0;
        end
        idle();
        for (int i = 0; i < 6; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
